// File: rtl/clsp_clkgn_div_core_if.sv
// Control/status bundle for the programmable clock divider: ratio and stretch in,
// divided clock and alignment pulses out.
interface clsp_clkgn_div_core_if;
  logic [4:0] div_ratio;
  logic       stretch_l;
  logic       dom_div;
  logic       align_edge;
  logic       align_edge_b;

  modport master (
    output div_ratio,
    output stretch_l,
    input  dom_div,
    input  align_edge,
    input  align_edge_b
  );

  modport slave (
    input  div_ratio,
    input  stretch_l,
    output dom_div,
    output align_edge,
    output align_edge_b
  );
endinterface

// File: rtl/clsp_clkgn_div_core.sv
// Programmable integer divider of pll_clk with stretch and period-boundary ratio updates.
// Optional scan chain enabled by defining CLKGN_SCAN_EN.
module clsp_clkgn_div_core #(
  parameter int unsigned MAX_DIV = 24,
  parameter int unsigned MIN_DIV = 2
) (
  input  logic                   pll_clk,
  input  logic                   init_l,
`ifdef CLKGN_SCAN_EN
  input  logic                   se,
  input  logic                   si,
  output logic                   so,
`endif
  clsp_clkgn_div_core_if.slave   bus
);

  localparam int unsigned CW = $clog2(MAX_DIV);
  localparam int unsigned NW = $clog2(MAX_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] cur_n_q, cur_n_d;
  logic          dom_q, dom_d;
  logic          align_q, align_d;
  logic          align_b_q, align_b_d;
  logic          strch_q, strch_d;
  logic [NW-1:0] req_n;
  logic          wrap;
  logic [NW:0]   half;

  function automatic logic [NW-1:0] clamp(input logic [4:0] x);
    if (32'(x) < MIN_DIV)      return NW'(MIN_DIV);
    else if (32'(x) > MAX_DIV) return NW'(MAX_DIV);
    else                       return NW'(x);
  endfunction

  assign req_n = clamp(bus.div_ratio);

  always_comb begin
    cnt_d     = cnt_q;
    cur_n_d   = cur_n_q;
    dom_d     = dom_q;
    align_d   = 1'b0;
    align_b_d = align_q;
    strch_d   = ~bus.stretch_l;
    wrap      = 1'b0;
    half      = '0;
    if (!init_l) begin
      cur_n_d   = req_n;
      cnt_d     = CW'(req_n - 1'b1);
      dom_d     = 1'b0;
      align_b_d = 1'b0;
      strch_d   = 1'b0;
    end else if (!strch_q) begin
      wrap    = (NW'(cnt_q) == cur_n_q - 1'b1);
      // A new ratio only takes effect on the period that starts at the wrap.
      cur_n_d = wrap ? req_n : cur_n_q;
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      half    = ({1'b0, cur_n_d} + 1'b1) >> 1;
      dom_d   = ({1'b0, NW'(cnt_d)} < half);
      align_d = (NW'(cnt_d) == cur_n_d - 1'b1) && !strch_d;
    end
  end

`ifdef CLKGN_SCAN_EN
  localparam int unsigned SW = 4 + CW + NW;
  logic [SW-1:0] chain;
  assign chain = {align_b_q, cur_n_q, cnt_q, align_q, dom_q, strch_q};
  assign so    = align_b_q;
`endif

  always_ff @(posedge pll_clk) begin
`ifdef CLKGN_SCAN_EN
    if (se) begin
      {align_b_q, cur_n_q, cnt_q, align_q, dom_q, strch_q} <= {chain[SW-2:0], si};
    end else
`endif
    begin
      cnt_q     <= cnt_d;
      cur_n_q   <= cur_n_d;
      dom_q     <= dom_d;
      align_q   <= align_d;
      align_b_q <= align_b_d;
      strch_q   <= strch_d;
    end
  end

  assign bus.dom_div      = dom_q;
  assign bus.align_edge   = align_q;
  assign bus.align_edge_b = align_b_q;

endmodule

// File: tb/tb_clsp_clkgn_div_core.sv
// Directed bench for clsp_clkgn_div_core: hand-written dom_div/align_edge patterns per scenario.
module tb_clsp_clkgn_div_core;
  logic pll_clk = 1'b0;
  logic init_l  = 1'b0;
`ifdef CLKGN_SCAN_EN
  logic se = 1'b0;
  logic si = 1'b0;
  logic so;
`endif
  int n_pass = 0;
  int n_chk  = 0;

  clsp_clkgn_div_core_if bus ();

  clsp_clkgn_div_core dut (
    .pll_clk (pll_clk),
    .init_l  (init_l),
`ifdef CLKGN_SCAN_EN
    .se      (se),
    .si      (si),
    .so      (so),
`endif
    .bus     (bus)
  );

  always #5 pll_clk = ~pll_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge pll_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".dom"}, bus.dom_div, 1'b0);
    chk({tag, ".al"}, bus.align_edge, 1'b0);
    chk({tag, ".alb"}, bus.align_edge_b, 1'b0);
  endtask

  // ds/as: expected dom_div/align_edge after each edge; align_edge_b is as shifted by one.
  task automatic run_pat(input string tag, input string ds, input string as, input logic ab0);
    logic ab;
    ab = ab0;
    for (int i = 0; i < ds.len(); i++) begin
      step();
      chk($sformatf("%s.dom[%0d]", tag, i), bus.dom_div, ds[i] == 8'h31);
      chk($sformatf("%s.al[%0d]", tag, i), bus.align_edge, as[i] == 8'h31);
      chk($sformatf("%s.alb[%0d]", tag, i), bus.align_edge_b, ab);
      ab = (as[i] == 8'h31);
    end
  endtask

  initial begin
    bus.div_ratio = 5'd4;
    bus.stretch_l = 1'b1;
    step();
    step();
    chk_zero("reset");

    init_l = 1'b1;
    run_pat("n4", "11001100", "00010001", 1'b0);

    bus.div_ratio = 5'd5;
    run_pat("n5", "1110011100", "0000100001", 1'b1);

    bus.div_ratio = 5'd4;
    run_pat("n4b", "11", "00", 1'b1);
    bus.div_ratio = 5'd6;
    run_pat("n4to6", "001110001", "010000010", 1'b0);

    bus.stretch_l = 1'b0;
    run_pat("strch_on", "111", "000", 1'b0);
    bus.stretch_l = 1'b1;
    run_pat("strch_off", "110001", "000010", 1'b0);

    // One-cycle reset while dom_div and align_edge_b are high.
    bus.div_ratio = 5'd0;
    init_l = 1'b0;
    step();
    chk_zero("mid_reset");
    init_l = 1'b1;
    run_pat("clamp_lo", "1010", "0101", 1'b0);

    bus.div_ratio = 5'd31;
    init_l = 1'b0;
    step();
    chk_zero("reset31");
    init_l = 1'b1;
    run_pat("clamp_hi", "11111111111100000000000011", "00000000000000000000000100", 1'b0);

    // Reset wins over a simultaneous stretch request.
    bus.div_ratio = 5'd4;
    init_l = 1'b0;
    bus.stretch_l = 1'b0;
    step();
    chk_zero("rst_strch");
    init_l = 1'b1;
    bus.stretch_l = 1'b1;
    run_pat("after_rs", "11001", "00010", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
